// File: rtl/exe_lsu_ctrl.sv
// rtl/exe_lsu_ctrl.sv - load/store unit controller between the execute stage and a req/gnt/rvalid data bus
//
// Purpose:
//   Accepts one RISC-V load or store from the execute stage, computes the
//   effective address, issues a single bus transaction with lane-positioned
//   byte enables and store data, waits for the response with a timeout, and
//   returns a one-cycle completion pulse with an optional load result or
//   exception cause.
//
// Configuration:
//   LSU_MISALIGN_TRAP_EN - when defined, misaligned accesses trap (cause 4/6)
//                          without touching the bus; when undefined, the
//                          address is aligned down to the access size.
//
// Ports:
//   clk_in, reset_n_in          clock, asynchronous active-low reset
//   valid_in / ready_out        instruction handshake (ready only in IDLE)
//   inst_in, op1_in, op2_in     instruction word, base register, store data
//   flush_in                    abandons a request that has not been granted
//   bus_req_out .. bus_wdata_out  bus request channel
//   bus_gnt_in                  request accepted
//   bus_rvalid_in, bus_rdata_in response / read data
//   reg_wdata_out, reg_we_out   load result write-back
//   done_out, exc_out, exc_cause_out  completion pulse and exception info
module exe_lsu_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [31:0]           inst_in,
  input  logic [DATA_W-1:0]     op1_in,
  input  logic [DATA_W-1:0]     op2_in,
  input  logic                  flush_in,
  output logic                  bus_req_out,
  output logic [ADDR_W-1:0]     bus_addr_out,
  output logic                  bus_we_out,
  output logic [DATA_W/8-1:0]   bus_be_out,
  output logic [DATA_W-1:0]     bus_wdata_out,
  input  logic                  bus_gnt_in,
  input  logic                  bus_rvalid_in,
  input  logic [DATA_W-1:0]     bus_rdata_in,
  output logic [DATA_W-1:0]     reg_wdata_out,
  output logic                  reg_we_out,
  output logic                  done_out,
  output logic                  exc_out,
  output logic [3:0]            exc_cause_out
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t           state;
  logic [7:0]       cnt;
  logic             is_store_q;
  logic [2:0]       f3_q;
  logic [OFF_W-1:0] off_q;

  // Instruction decode and address generation (all combinational on inputs).
  logic [6:0]        opcode;
  logic              is_load, is_store, legal;
  logic [2:0]        f3;
  logic [1:0]        size;
  logic [11:0]       imm;
  logic [2:0]        size_lowmask;
  logic [ADDR_W-1:0] eff_addr, acc_addr, word_addr;
  logic              misalign_trap;
  logic [OFF_W-1:0]  off;
  logic [BE_W-1:0]   lane_mask, be_next;
  logic [DATA_W-1:0] data_mask, wdata_next;
  logic              unused_rs1;

  assign opcode   = inst_in[6:0];
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign f3       = inst_in[14:12];
  assign size     = f3[1:0];
  assign imm      = is_store ? {inst_in[31:25], inst_in[11:7]} : inst_in[31:20];
  assign eff_addr = ADDR_W'(op1_in) + ADDR_W'($signed(imm));
  assign unused_rs1 = ^inst_in[19:15];

  // Low address bits that must be zero for a naturally aligned access.
  assign size_lowmask = {size == 2'd3, size >= 2'd2, size >= 2'd1};

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_trap = |(eff_addr[2:0] & size_lowmask);
  assign acc_addr      = eff_addr;
`else
  assign misalign_trap = 1'b0;
  assign acc_addr      = eff_addr & ~ADDR_W'(size_lowmask);
`endif

  assign word_addr = acc_addr & ~ADDR_W'(BE_W - 1);
  assign off       = acc_addr[OFF_W-1:0];

  always_comb begin
    legal = 1'b0;
    if (is_load) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = (DATA_W == 64);
        default:                                legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (f3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = (DATA_W == 64);
        default:                legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (size)
      2'd0:    lane_mask = BE_W'(1);
      2'd1:    lane_mask = BE_W'(3);
      2'd2:    lane_mask = BE_W'(15);
      default: lane_mask = BE_W'(255);
    endcase
    data_mask = '0;
    for (int i = 0; i < BE_W; i++) data_mask[i*8 +: 8] = {8{lane_mask[i]}};
    be_next    = lane_mask << off;
    wdata_next = (op2_in & data_mask) << {off, 3'b000};
  end

  // Load result: move the addressed lane down to bit 0, then extend.
  logic [DATA_W-1:0] rd_shift, ld_result;
  always_comb begin
    rd_shift = bus_rdata_in >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_result = DATA_W'($signed(rd_shift[7:0]));
      3'b001:  ld_result = DATA_W'($signed(rd_shift[15:0]));
      3'b010:  ld_result = DATA_W'($signed(rd_shift[31:0]));
      3'b100:  ld_result = DATA_W'(rd_shift[7:0]);
      3'b101:  ld_result = DATA_W'(rd_shift[15:0]);
      3'b110:  ld_result = DATA_W'(rd_shift[31:0]);
      default: ld_result = rd_shift;
    endcase
  end

  assign ready_out = (state == S_IDLE);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state         <= S_IDLE;
      cnt           <= '0;
      is_store_q    <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      bus_req_out   <= 1'b0;
      bus_addr_out  <= '0;
      bus_we_out    <= 1'b0;
      bus_be_out    <= '0;
      bus_wdata_out <= '0;
      reg_wdata_out <= '0;
      reg_we_out    <= 1'b0;
      done_out      <= 1'b0;
      exc_out       <= 1'b0;
      exc_cause_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_in && (is_load || is_store)) begin
            is_store_q <= is_store;
            f3_q       <= f3;
            off_q      <= off;
            cnt        <= '0;
            if (!legal) begin
              state         <= S_DONE;
              done_out      <= 1'b1;
              exc_out       <= 1'b1;
              exc_cause_out <= 4'd2;
              reg_we_out    <= 1'b0;
            end else if (misalign_trap) begin
              state         <= S_DONE;
              done_out      <= 1'b1;
              exc_out       <= 1'b1;
              exc_cause_out <= is_store ? 4'd6 : 4'd4;
              reg_we_out    <= 1'b0;
            end else begin
              state         <= S_REQ;
              bus_req_out   <= 1'b1;
              bus_addr_out  <= word_addr;
              bus_be_out    <= be_next;
              bus_wdata_out <= wdata_next;
              bus_we_out    <= is_store;
            end
          end
        end
        S_REQ: begin
          // Grant wins over a simultaneous flush: the bus has already taken it.
          if (bus_gnt_in) begin
            state       <= S_WAIT;
            bus_req_out <= 1'b0;
            bus_we_out  <= 1'b0;
            cnt         <= '0;
          end else if (flush_in) begin
            state       <= S_IDLE;
            bus_req_out <= 1'b0;
            bus_we_out  <= 1'b0;
          end
        end
        S_WAIT: begin
          // A response in the limit cycle still counts as a response.
          if (bus_rvalid_in) begin
            state         <= S_DONE;
            done_out      <= 1'b1;
            exc_out       <= 1'b0;
            exc_cause_out <= 4'd0;
            reg_we_out    <= !is_store_q;
            if (!is_store_q) reg_wdata_out <= ld_result;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state         <= S_DONE;
            done_out      <= 1'b1;
            exc_out       <= 1'b1;
            exc_cause_out <= is_store_q ? 4'd7 : 4'd5;
            reg_we_out    <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state      <= S_IDLE;
          done_out   <= 1'b0;
          exc_out    <= 1'b0;
          reg_we_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_lsu_ctrl.sv
// tb/tb_exe_lsu_ctrl.sv - self-checking bench for exe_lsu_ctrl with a behavioural access model
module tb_exe_lsu_ctrl;

  localparam int TMO = 4;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        valid_in, flush_in, bus_gnt_in, bus_rvalid_in;
  logic [31:0] inst_in, op1_in, op2_in, bus_rdata_in;
  logic        ready_out, bus_req_out, bus_we_out, reg_we_out, done_out, exc_out;
  logic [31:0] bus_addr_out, bus_wdata_out, reg_wdata_out;
  logic [3:0]  bus_be_out, exc_cause_out;

  int total = 0;
  int bad   = 0;

  exe_lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .valid_in(valid_in), .ready_out(ready_out),
    .inst_in(inst_in), .op1_in(op1_in), .op2_in(op2_in), .flush_in(flush_in),
    .bus_req_out(bus_req_out), .bus_addr_out(bus_addr_out), .bus_we_out(bus_we_out),
    .bus_be_out(bus_be_out), .bus_wdata_out(bus_wdata_out),
    .bus_gnt_in(bus_gnt_in), .bus_rvalid_in(bus_rvalid_in), .bus_rdata_in(bus_rdata_in),
    .reg_wdata_out(reg_wdata_out), .reg_we_out(reg_we_out),
    .done_out(done_out), .exc_out(exc_out), .exc_cause_out(exc_cause_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_load(input int f3, input int imm, input int rs1);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, 5'(rs1), 3'(f3), 5'd5, 7'h03};
  endfunction

  function automatic logic [31:0] mk_store(input int f3, input int imm, input int rs1);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12[11:5], 5'd7, 5'(rs1), 3'(f3), i12[4:0], 7'h23};
  endfunction

  // One access from IDLE back to IDLE. Starts and ends at a falling edge.
  // fmode: 0 = normal, 1 = flush alone in REQ cycle gdly, 2 = flush with grant.
  task automatic txn(input string tag, input logic [31:0] ti, input logic [31:0] o1,
                     input logic [31:0] o2, input logic [31:0] rd,
                     input int gdly, input int rdly, input int fmode);
    bit ld, st, legal, mis, trap_en, early, tmo;
    int f3, immv, n, off, early_cause;
    logic [31:0] addr, al, exp_addr, exp_wd, exp_res;
    logic [3:0] exp_be;
    longint unsigned lim, v;

`ifdef LSU_MISALIGN_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    ld = (ti[6:0] == 7'h03);
    st = (ti[6:0] == 7'h23);
    f3 = int'(ti[14:12]);
    immv = st ? int'({ti[31:25], ti[11:7]}) : int'(ti[31:20]);
    if (immv >= 2048) immv -= 4096;
    addr = o1 + 32'(immv);
    n = 1 << (f3 % 4);
    legal = ld ? (f3 inside {0, 1, 2, 4, 5}) : (f3 inside {0, 1, 2});
    mis = (addr % n) != 0;
    early = 1'b0;
    early_cause = 0;
    if (!legal) begin
      early = 1'b1; early_cause = 2;
    end else if (trap_en && mis) begin
      early = 1'b1; early_cause = ld ? 4 : 6;
    end
    al = addr - addr % n;
    exp_addr = al - al % 4;
    off = int'(al % 4);
    exp_be = 4'(((1 << n) - 1) << off);
    lim = 64'd1 << (8 * n);
    exp_wd = 32'((longint'(o2) % lim) << (8 * off));
    v = (longint'(rd) >> (8 * off)) % lim;
    if (f3 < 4 && v >= lim / 2) v = v - lim;
    exp_res = v[31:0];
    tmo = (rdly >= TMO);

    chk({tag, ".ready"}, ready_out, 1);
    valid_in = 1'b1; inst_in = ti; op1_in = o1; op2_in = o2;
    @(negedge clk_in);
    valid_in = 1'b0; inst_in = $urandom; op1_in = $urandom; op2_in = $urandom;

    if (!(ld || st)) begin
      chk({tag, ".ign_ready"}, ready_out, 1);
      chk({tag, ".ign_req"}, bus_req_out, 0);
      chk({tag, ".ign_done"}, done_out, 0);
      return;
    end
    if (early) begin
      chk({tag, ".e_done"}, done_out, 1);
      chk({tag, ".e_exc"}, exc_out, 1);
      chk({tag, ".e_cause"}, exc_cause_out, 64'(early_cause));
      chk({tag, ".e_req"}, bus_req_out, 0);
      chk({tag, ".e_we"}, reg_we_out, 0);
      @(negedge clk_in);
      chk({tag, ".e_done0"}, done_out, 0);
      chk({tag, ".e_ready"}, ready_out, 1);
      return;
    end

    for (int c = 0; c <= gdly; c++) begin
      chk({tag, ".req"}, bus_req_out, 1);
      chk({tag, ".req_ready"}, ready_out, 0);
      chk({tag, ".addr"}, bus_addr_out, exp_addr);
      chk({tag, ".be"}, bus_be_out, exp_be);
      chk({tag, ".bwe"}, bus_we_out, 64'(st));
      if (st) chk({tag, ".wdata"}, bus_wdata_out, exp_wd);
      if (c == gdly) begin
        if (fmode == 1) begin
          flush_in = 1'b1;
          @(negedge clk_in);
          flush_in = 1'b0;
          chk({tag, ".fl_ready"}, ready_out, 1);
          chk({tag, ".fl_req"}, bus_req_out, 0);
          chk({tag, ".fl_done"}, done_out, 0);
          @(negedge clk_in);
          chk({tag, ".fl_done2"}, done_out, 0);
          return;
        end
        bus_gnt_in = 1'b1;
        flush_in = (fmode == 2);
      end
      @(negedge clk_in);
      bus_gnt_in = 1'b0;
      flush_in = 1'b0;
    end

    for (int k = 0; k < TMO; k++) begin
      chk({tag, ".w_req"}, bus_req_out, 0);
      chk({tag, ".w_done"}, done_out, 0);
      flush_in = 1'($urandom);
      bus_rvalid_in = (k == rdly);
      bus_rdata_in = (k == rdly) ? rd : $urandom;
      @(negedge clk_in);
      bus_rvalid_in = 1'b0;
      flush_in = 1'b0;
      if (k == rdly) break;
    end

    chk({tag, ".done"}, done_out, 1);
    chk({tag, ".exc"}, exc_out, 64'(tmo));
    if (tmo) chk({tag, ".cause"}, exc_cause_out, ld ? 5 : 7);
    chk({tag, ".reg_we"}, reg_we_out, 64'(ld && !tmo));
    if (ld && !tmo) chk({tag, ".result"}, reg_wdata_out, exp_res);
    @(negedge clk_in);
    chk({tag, ".done0"}, done_out, 0);
    chk({tag, ".ready1"}, ready_out, 1);
  endtask

  initial begin
    logic [31:0] ti;
    reset_n_in = 1'b0; valid_in = 1'b0; flush_in = 1'b0; bus_gnt_in = 1'b0;
    bus_rvalid_in = 1'b0; inst_in = '0; op1_in = '0; op2_in = '0; bus_rdata_in = '0;
    repeat (2) @(negedge clk_in);
    chk("rst.req", bus_req_out, 0);
    chk("rst.done", done_out, 0);
    chk("rst.exc", exc_out, 0);
    chk("rst.addr", bus_addr_out, 0);
    chk("rst.be", bus_be_out, 0);
    chk("rst.regwd", reg_wdata_out, 0);
    reset_n_in = 1'b1;
    @(negedge clk_in);
    chk("rst.ready", ready_out, 1);

    // rvalid while idle is ignored
    bus_rvalid_in = 1'b1; bus_rdata_in = 32'hDEAD_BEEF;
    @(negedge clk_in);
    bus_rvalid_in = 1'b0;
    chk("idle_rv.done", done_out, 0);
    chk("idle_rv.we", reg_we_out, 0);

    // directed cases
    txn("lb", mk_load(0, 3, 1), 32'h1000, 32'h0, 32'h80FF_FF00, 0, 0, 0);
    txn("sh", mk_store(1, 2, 1), 32'h2000, 32'h0000_ABCD, 32'h0, 0, 0, 0);
    txn("lw_mis", mk_load(2, 1, 1), 32'h1000, 32'h0, 32'h1234_5678, 0, 0, 0);
    txn("sw_mis", mk_store(2, -2, 1), 32'h3001, 32'h5566_7788, 32'h0, 0, 1, 0);
    txn("ld_ill", mk_load(3, 0, 1), 32'h1000, 32'h0, 32'h0, 0, 0, 0);
    txn("st_ill", mk_store(5, 0, 1), 32'h1000, 32'h0, 32'h0, 0, 0, 0);
    txn("nonls", 32'h0020_81B3, 32'h1000, 32'h0, 32'h0, 0, 0, 0);
    txn("tmo_ld", mk_load(2, 0, 1), 32'h4000, 32'h0, 32'h0, 0, TMO + 3, 0);
    txn("tmo_st", mk_store(0, 5, 1), 32'h4000, 32'h77, 32'h0, 1, TMO, 0);
    txn("tmo_race", mk_load(5, 6, 1), 32'h4000, 32'h0, 32'hFACE_8001, 0, TMO - 1, 0);
    txn("bp", mk_store(2, 8, 1), 32'h5000, 32'hCAFE_F00D, 32'h0, 10, 0, 0);
    txn("flush", mk_load(1, 2, 1), 32'h5000, 32'h0, 32'h0, 5, 0, 1);
    txn("flush_gnt", mk_load(4, 1, 1), 32'h5000, 32'h0, 32'h0000_9900, 3, 1, 2);

    // reset in WAIT: outputs drop at once, late response ignored
    valid_in = 1'b1; inst_in = mk_store(2, 4, 1); op1_in = 32'h6000; op2_in = 32'h1111_2222;
    @(negedge clk_in);
    valid_in = 1'b0;
    bus_gnt_in = 1'b1;
    @(negedge clk_in);
    bus_gnt_in = 1'b0;
    #2 reset_n_in = 1'b0;
    #1;
    chk("rstw.addr", bus_addr_out, 0);
    chk("rstw.be", bus_be_out, 0);
    chk("rstw.wdata", bus_wdata_out, 0);
    chk("rstw.done", done_out, 0);
    chk("rstw.cause", exc_cause_out, 0);
    chk("rstw.ready", ready_out, 1);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    bus_rvalid_in = 1'b1;
    @(negedge clk_in);
    bus_rvalid_in = 1'b0;
    chk("rstw.late_done", done_out, 0);
    chk("rstw.late_ready", ready_out, 1);
    @(negedge clk_in);
    chk("rstw.late_done2", done_out, 0);

    // randomized accesses
    for (int r = 0; r < 60; r++) begin
      int sel, f3, imm;
      sel = int'($urandom_range(0, 9));
      f3  = int'($urandom_range(0, 7));
      imm = int'($urandom_range(0, 4095));
      if (sel == 0)      ti = 32'h0000_0033 | ($urandom & 32'hFFFF_FF80);
      else if (sel < 6)  ti = mk_load(f3, imm, int'($urandom_range(0, 31)));
      else               ti = mk_store(f3, imm, int'($urandom_range(0, 31)));
      txn("rnd", ti, $urandom, $urandom, $urandom,
          int'($urandom_range(0, 3)), int'($urandom_range(0, TMO + 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
